ram_sp_responder: RTL and testbench
===================================

// Module: ram_sp_responder
// PURPOSE
//  Single-port synchronous RAM responder; the target side of the ram_en/ram_we/ram_addr/ram_wr_data/ram_rd_data
//  interface driven by the RAM read/write test generator.
//  Replaces the vendor 1-port RAM IP in simulation and on-chip self-test builds.
//  Adds selectable read latency, write-collision modes, access counters and optional parity checking.
// PARAMETERS
//  DATA_W      8   word width, bits
//  ADDR_W      5   address width; depth = 2**ADDR_W
//  RD_LATENCY  1   read latency in cycles; legal values 1 or 2
//  WR_MODE     0   read data on a write: 0 READ_FIRST (old word), 1 WRITE_FIRST (new word), 2 NO_CHANGE (hold)
//  CNT_W       16  width of the access counters
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst_n        in   1       asynchronous reset, active low
//  ram_en       in   1       access enable
//  ram_we       in   1       write enable; qualified by ram_en
//  ram_addr     in   ADDR_W  word address
//  ram_wr_data  in   DATA_W  write data
//  ram_rd_data  out  DATA_W  read data
//  rd_valid     out  1       ram_rd_data is valid this cycle
//  wr_cnt       out  CNT_W   count of accepted writes, saturating
//  rd_cnt       out  CNT_W   count of accepted reads, saturating
//  par_err      out  1       parity error on the current read word (RAM_PARITY_EN only)
//  par_inj      in   1       corrupt parity of the current write (RAM_PARITY_EN only)
// BEHAVIOUR
//  - Reset: ram_rd_data=0, rd_valid=0, wr_cnt=0, rd_cnt=0, par_err=0, latency pipeline cleared.
//    Array contents are not reset; words are X until first written.
//  - Access at edge N with ram_en=1. Write when ram_we=1; read when ram_we=0. ram_en=0 is idle: no array
//    change; ram_rd_data holds its last value.
//  - Write: mem[ram_addr] <= ram_wr_data at edge N. The word is readable by a read issued at edge N+1.
//  - Read: the word is on ram_rd_data after edge N+RD_LATENCY-1+1, i.e. the next cycle for latency 1 and two
//    cycles later for latency 2. rd_valid=1 in exactly that cycle.
//  - Latency 2: the array register feeds the output register; the pipeline advances every cycle.
//    Back-to-back reads give one word per cycle.
//  - Write data path, timed like a read:
//    READ_FIRST: the old word appears on ram_rd_data.
//    WRITE_FIRST: ram_wr_data appears.
//    NO_CHANGE: ram_rd_data holds.
//    rd_valid stays 0 for writes in all modes.
//  - Counters: wr_cnt +1 per write and rd_cnt +1 per read. Each saturates at 2**CNT_W-1 and never wraps.
//  - Addressing: out-of-range addresses cannot occur (full decode). Address wrap-around (e.g. 31->0) is the
//    master's concern; no special handling.
//  - Reset mid-operation: in-flight reads are discarded (rd_valid=0 next cycle). Writes accepted before
//    reset persist in the array.
//  - ram_we with ram_en=0 is ignored: no write, no count.
// CONFIGURATION
//  RAM_PARITY_EN defined:
//   - Array width becomes DATA_W+1; stored bit = ^ram_wr_data, XOR par_inj.
//   - On each read return, par_err=1 in the rd_valid cycle if the recomputed parity mismatches; else par_err=0.
//   - Ports par_err and par_inj are present.
//  RAM_PARITY_EN undefined:
//   - Array is DATA_W wide; no parity logic.
//   - par_err and par_inj ports are absent.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> all outputs 0 within the same cycle; array words written earlier
//    read back intact.
//  2 Fill: write addr 0..31 with data 0..31, then read 0..31 (RD_LATENCY=1) -> data 0..31, one per cycle;
//    rd_valid high 32 cycles; wr_cnt=32, rd_cnt=32.
//  3 Latency 2: same fill/readback -> each word lags its address by 2 cycles; no gaps.
//  4 Collision: mem[5]=0xAA, write 0x55 to 5 -> rd_data 0xAA (mode 0), 0x55 (mode 1), holds previous (mode 2).
//  5 Idle: ram_en=0, ram_we=1, addr 3, data 0xFF for 4 cycles -> mem[3] unchanged; counters unchanged;
//    rd_data held.
//  6 Parity (RAM_PARITY_EN): write 0x0F to 7 with par_inj=1, read 7 -> par_err=1 with rd_valid;
//    read a clean word -> par_err=0.

Source files
------------

// File: rtl/ram_sp_responder.sv
// Single-port synchronous RAM target: 1- or 2-cycle read latency, selectable write-collision read
// data, saturating access counters. Define RAM_PARITY_EN to add a stored parity bit per word.
module ram_sp_responder #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int RD_LATENCY = 1,
  parameter int WR_MODE    = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
`ifdef RAM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] ram_rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int DEPTH            = 2 ** ADDR_W;
  localparam int MODE_WRITE_FIRST = 1;
  localparam int MODE_NO_CHANGE   = 2;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              acc_rd, acc_wr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  s0_word;
  logic              s0_load;
  logic [MEM_W-1:0]  last_word;
  logic              last_load, last_valid;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q;

  assign acc_rd = ram_en & ~ram_we;
  assign acc_wr = ram_en & ram_we;

`ifdef RAM_PARITY_EN
  assign wr_word = {(^ram_wr_data) ^ par_inj, ram_wr_data};
`else
  assign wr_word = ram_wr_data;
`endif

  // Word entering the read pipeline; writes either return the old word, the new word, or nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s0_word = mem[ram_addr];
    if (acc_wr && (WR_MODE == MODE_WRITE_FIRST)) s0_word = wr_word;
    s0_load = acc_rd | (acc_wr & (WR_MODE != MODE_NO_CHANGE));
  end

  // NOTE: the array has no reset; contents must survive rst_n and map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (acc_wr) mem[ram_addr] <= wr_word;
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [MEM_W-1:0] s1_word_q;
    logic             s1_load_q, s1_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_word_q  <= '0;
        s1_load_q  <= 1'b0;
        s1_valid_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        s1_word_q  <= s0_word;
        s1_load_q  <= s0_load;
        s1_valid_q <= acc_rd;
      end
    end

    assign last_word  = s1_word_q;
    assign last_load  = s1_load_q;
    assign last_valid = s1_valid_q;
  end else begin : g_lat1
    assign last_word  = s0_word;
    assign last_load  = s0_load;
    assign last_valid = acc_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= last_valid;
      if (last_load) rd_data_q <= last_word[DATA_W-1:0];
    end
  end

`ifdef RAM_PARITY_EN
  logic par_err_q;

  // Stored parity folds into the word, so any odd total means a corrupted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= last_valid & (^last_word);
  end

  assign par_err = par_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (acc_wr && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (acc_rd && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
    end
  end

  assign ram_rd_data = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;

endmodule

// File: tb/tb_ram_sp_responder.sv
// Scoreboard bench for ram_sp_responder: three configurations share one stimulus stream;
// a word-level model predicts each one's output per cycle and a monitor compares.
module tb_ram_sp_responder;

  localparam int NI = 3;

  typedef struct packed {
    int unsigned          cyc;
    logic                 valid;
    logic [NI-1:0][7:0]   d;
    logic [NI-1:0]        known;
    logic                 perr;
    int unsigned          wc;
    int unsigned          rc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ram_en = 1'b0;
  logic              ram_we = 1'b0;
  logic [4:0]        ram_addr = '0;
  logic [7:0]        ram_wr_data = '0;
  logic              par_inj = 1'b0;
  logic [NI-1:0][7:0] rd_data;
  logic [NI-1:0]     rd_valid;
  logic [NI-1:0]     par_err;
  logic [15:0]       wc0, rc0;
  logic [3:0]        wc1, rc1;
  logic [4:0]        wc2, rc2;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  logic [7:0]  mem_m [32];
  bit          known_m [32];
  bit          bad_m [32];
  logic [7:0]  out_m [NI];
  bit          out_known [NI];
  int unsigned wc_m = 0, rc_m = 0;
  exp_t        q[$];
  exp_t        cur, prev;
  bit          cur_ok, prev_ok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: latency 1 READ_FIRST; u1: latency 2 WRITE_FIRST, 4-bit counters; u2: latency 1 NO_CHANGE, 5-bit counters
  ram_sp_responder #(.DATA_W(8), .ADDR_W(5), .RD_LATENCY(1), .WR_MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err[0]),
`endif
    .ram_rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .wr_cnt(wc0), .rd_cnt(rc0));

  ram_sp_responder #(.DATA_W(8), .ADDR_W(5), .RD_LATENCY(2), .WR_MODE(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err[1]),
`endif
    .ram_rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .wr_cnt(wc1), .rd_cnt(rc1));

  ram_sp_responder #(.DATA_W(8), .ADDR_W(5), .RD_LATENCY(1), .WR_MODE(2), .CNT_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err[2]),
`endif
    .ram_rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .wr_cnt(wc2), .rd_cnt(rc2));

`ifndef RAM_PARITY_EN
  assign par_err = '0;
`endif

  function automatic int lat_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int unsigned sat(int unsigned x, int w);
    int unsigned mx = (32'd1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  // One access per call; the model applies the word-level rules and queues the expected outcome.
  task automatic step(input bit en, input bit we, input logic [4:0] a, input logic [7:0] d,
                      input bit inj);
    exp_t e;
    @(posedge clk);
    #2;
    ram_en = en; ram_we = we; ram_addr = a; ram_wr_data = d; par_inj = inj;
    for (int i = 0; i < NI; i++) begin
      if (en && !we) begin
        out_m[i] = mem_m[a]; out_known[i] = known_m[a];
      end else if (en && we && i == 0) begin
        out_m[i] = mem_m[a]; out_known[i] = known_m[a];
      end else if (en && we && i == 1) begin
        out_m[i] = d; out_known[i] = 1'b1;
      end
    end
    e.perr = en && !we && bad_m[a];
    if (en && we) begin
      mem_m[a] = d; known_m[a] = 1'b1; bad_m[a] = inj; wc_m++;
    end
    if (en && !we) rc_m++;
    e.cyc = cyc + 1; e.valid = en && !we; e.wc = wc_m; e.rc = rc_m;
    for (int i = 0; i < NI; i++) begin
      e.d[i] = out_m[i]; e.known[i] = out_known[i];
    end
    q.push_back(e);
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d reset rd_valid", i), 32'(rd_valid[i]), 32'd0);
      check($sformatf("u%0d reset rd_data", i), 32'(rd_data[i]), 32'd0);
      check($sformatf("u%0d reset par_err", i), 32'(par_err[i]), 32'd0);
    end
    check("reset counters", {wc0, rc0}, 32'd0);
    check("reset small counters", 32'({wc1, rc1, wc2, rc2}), 32'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0; ram_en = 1'b0; ram_we = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    for (int i = 0; i < NI; i++) begin
      out_m[i] = 8'h00; out_known[i] = 1'b1;
    end
    wc_m = 0; rc_m = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic check_out(input int i, input bit ok, input exp_t e);
    if (ok) begin
      check($sformatf("u%0d rd_valid", i), 32'(rd_valid[i]), 32'(e.valid));
      if (e.known[i]) check($sformatf("u%0d rd_data", i), 32'(rd_data[i]), 32'(e.d[i]));
`ifdef RAM_PARITY_EN
      check($sformatf("u%0d par_err", i), 32'(par_err[i]), 32'(e.perr));
`endif
    end else begin
      check($sformatf("u%0d idle rd_valid", i), 32'(rd_valid[i]), 32'd0);
    end
  endtask

  // Monitor: pops the entry due this cycle; the latency-2 instance is compared one entry behind.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ok = 1'b0;
      end else begin
        cur_ok = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
          void'(q.pop_front());
          check("stale scoreboard entry", 32'd1, 32'd0);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          cur = q.pop_front(); cur_ok = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
          if (lat_of(i) == 1) check_out(i, cur_ok, cur);
          else                check_out(i, prev_ok && (prev.cyc == cyc - 1), prev);
        end
        if (cur_ok) begin
          check("u0 wr_cnt", 32'(wc0), sat(cur.wc, 16));
          check("u0 rd_cnt", 32'(rc0), sat(cur.rc, 16));
          check("u1 wr_cnt", 32'(wc1), sat(cur.wc, 4));
          check("u1 rd_cnt", 32'(rc1), sat(cur.rc, 4));
          check("u2 wr_cnt", 32'(wc2), sat(cur.wc, 5));
          check("u2 rd_cnt", 32'(rc2), sat(cur.rc, 5));
        end
        prev = cur; prev_ok = cur_ok;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      out_m[i] = 8'h00; out_known[i] = 1'b1;
    end
    for (int a = 0; a < 32; a++) begin
      known_m[a] = 1'b0; bad_m[a] = 1'b0;
    end
    #3;
    check_reset_vals();
    #9 rst_n = 1'b1;

    for (int a = 0; a < 32; a++) step(1, 1, 5'(a), 8'(a), 0);
    for (int a = 0; a < 32; a++) step(1, 0, 5'(a), 8'h00, 0);

    step(1, 1, 5'd5, 8'hAA, 0);
    step(1, 0, 5'd9, 8'h00, 0);
    step(1, 1, 5'd5, 8'h55, 0);
    step(0, 0, 5'd0, 8'h00, 0);
    step(1, 0, 5'd5, 8'h00, 0);

    repeat (4) step(0, 1, 5'd3, 8'hFF, 0);
    step(1, 0, 5'd3, 8'h00, 0);

`ifdef RAM_PARITY_EN
    step(1, 1, 5'd7, 8'h0F, 1);
    step(1, 0, 5'd7, 8'h00, 0);
    step(1, 0, 5'd8, 8'h00, 0);
`endif

    for (int n = 0; n < 400; n++) begin
      bit inj = 1'b0;
`ifdef RAM_PARITY_EN
      inj = ($urandom_range(0, 7) == 0);
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom), 8'($urandom), inj);
    end

    step(1, 0, 5'd2, 8'h00, 0);
    step(1, 0, 5'd3, 8'h00, 0);
    mid_reset();
    for (int a = 0; a < 32; a++) step(1, 0, 5'(a), 8'h00, 0);

    for (int n = 0; n < 100; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom), 8'($urandom), 0);
    repeat (3) step(0, 0, 5'd0, 8'h00, 0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
